// File: rtl/regfile.sv
// Two-read/one-write register file with r0 hardwired to zero,
// optional same-cycle write bypass and a stored-contents debug port.
module regfile #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    output logic [WIDTH-1:0]  rd1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int NREG = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [NREG-1:1];
    logic [WIDTH-1:0] view [NREG];
    logic             wr_en;
    logic             hit1;
    logic             hit2;

    assign wr_en = rst_n && we3 && (wa3 != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa3] <= wd3;
        end
    end

    // Full-size view so every address encoding decodes to defined data.
    assign view[0] = '0;
    for (genvar g = 1; g < NREG; g++) begin : g_view
        assign view[g] = regs[g];
    end

    assign hit1 = BYPASS && wr_en && (wa3 == ra1);
    assign hit2 = BYPASS && wr_en && (wa3 == ra2);

    always_comb begin
        rd1      = '0;
        rd2      = '0;
        dbg_data = '0;
        if (rst_n) begin
            rd1      = hit1 ? wd3 : view[ra1];
            rd2      = hit2 ? wd3 : view[ra2];
            dbg_data = view[dbg_addr];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Randomized and directed bench for regfile, comparing both bypass
// variants against an array-based reference model.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa3, dbg_addr;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] rd1_b, rd2_b, dbg_b;
    logic [31:0] rd1_n, rd2_n, dbg_n;

    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .rd1(rd1_b), .ra2(ra2), .rd2(rd2_b),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .dbg_addr(dbg_addr), .dbg_data(dbg_b)
    );

    regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .rd1(rd1_n), .ra2(ra2), .rd2(rd2_n),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .dbg_addr(dbg_addr), .dbg_data(dbg_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                           input bit byp);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (byp && we3 && wa3 == a) return wd3;
        return model[a];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
        return model[a];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "/rd1_byp"}, rd1_b, exp_rd(ra1, 1'b1));
        chk({tag, "/rd2_byp"}, rd2_b, exp_rd(ra2, 1'b1));
        chk({tag, "/dbg_byp"}, dbg_b, exp_dbg(dbg_addr));
        chk({tag, "/rd1_nob"}, rd1_n, exp_rd(ra1, 1'b0));
        chk({tag, "/rd2_nob"}, rd2_n, exp_rd(ra2, 1'b0));
        chk({tag, "/dbg_nob"}, dbg_n, exp_dbg(dbg_addr));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && we3 && wa3 != 5'd0) model[wa3] = wd3;
        #1;
    endtask

    task automatic set_in(input logic w, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] da);
        we3 = w; wa3 = wa; wd3 = wd;
        ra1 = a1; ra2 = a2; dbg_addr = da;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        set_in(1'b1, a, d, 5'd0, 5'd0, 5'd0);
        tick();
        we3 = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        clear_model();
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd7);
        check_all("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-cycle after writing r5.
        write_reg(5'd5, 32'hDEADBEEF);
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        check_all("r5_written");
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("async_reset_rd1", rd1_b, 32'h0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk("reset_dbg_b", dbg_b, 32'h0);
        end
        // Write presented while reset is held: target must stay zero.
        set_in(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9, 5'd9);
        check_all("reset_write_pre");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b0, 5'd9, 32'h0, 5'd9, 5'd5, 5'd9);
        check_all("reset_write_post");
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk("post_reset_dbg_n", dbg_n, 32'h0);
        end

        // Basic write/read.
        write_reg(5'd7, 32'h12345678);
        write_reg(5'd31, 32'hFFFFFFFF);
        set_in(1'b0, 5'd0, 32'h0, 5'd7, 5'd31, 5'd7);
        chk("r7_rd1", rd1_b, 32'h12345678);
        chk("r31_rd2", rd2_n, 32'hFFFFFFFF);
        check_all("wr_rd");

        // Walking one across every register.
        for (int i = 0; i < 32; i++) write_reg(5'(i), 32'h1 << i);
        for (int i = 0; i < 32; i++) begin
            set_in(1'b0, 5'd0, 32'h0, 5'(i), 5'((i + 1) % 32), 5'(i));
            check_all("walk");
        end

        // r0 writes discarded, before and after the edge.
        set_in(1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0);
        chk("r0_pre_rd1", rd1_b, 32'h0);
        chk("r0_pre_rd2", rd2_b, 32'h0);
        check_all("r0_pre");
        tick();
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        chk("r0_post_dbg", dbg_b, 32'h0);
        check_all("r0_post");

        // Bypass vs non-bypass read-during-write.
        write_reg(5'd3, 32'h11111111);
        set_in(1'b1, 5'd3, 32'h22222222, 5'd3, 5'd3, 5'd3);
        chk("byp_rd1", rd1_b, 32'h22222222);
        chk("byp_rd2", rd2_b, 32'h22222222);
        chk("byp_dbg", dbg_b, 32'h11111111);
        chk("nob_rd1_pre", rd1_n, 32'h11111111);
        check_all("bypass_pre");
        tick();
        we3 = 1'b0;
        #1;
        chk("nob_rd1_post", rd1_n, 32'h22222222);
        check_all("bypass_post");

        // Write disabled: no change and no forwarding.
        set_in(1'b0, 5'd3, 32'h33333333, 5'd3, 5'd3, 5'd3);
        chk("wdis_pre", rd1_b, 32'h22222222);
        tick();
        chk("wdis_post", dbg_n, 32'h22222222);
        check_all("wdis");

        // Subtract on operands A=rd1, B=rd2.
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd3);
        set_in(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd1);
        chk("alu_y", rd1_b - rd2_b, 32'd2);
        chk("alu_zero", {31'h0, (rd1_n - rd2_n) == 32'h0}, 32'h0);
        write_reg(5'd2, 32'd5);
        set_in(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd2);
        chk("alu_zero2", {31'h0, (rd1_b - rd2_b) == 32'h0}, 32'h1);

        // Randomized traffic with forced address collisions.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            set_in(1'($urandom_range(0, 1)), wa, $urandom,
                   ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)));
            check_all("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
